// File: rtl/adc_pkg.sv
// Shared constants for the ADC capture path.
// Selects where packed samples come from.
package adc_pkg;
    localparam logic MODE_ADC  = 1'b0;
    localparam logic MODE_RAMP = 1'b1;
endpackage

// File: rtl/adc_pack_fifo.sv
// Generic first-word-fall-through FIFO: the head word is always visible on pop_data.
// Push and pop may happen on the same edge while the FIFO is full.
module adc_pack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      fill
);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == FULL_LEVEL);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/adc_sample_packer.sv
// Packs PACK consecutive multi-channel ADC samples into one word and queues it in an
// output FIFO, with a ramp test source and sticky overflow / saturating drop counting.
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int CHANNELS   = 1,
    parameter int PACK       = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              mode,
    input  logic                              in_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0]      in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PACK*CHANNELS*SAMPLE_W-1:0] out_data,
    output logic [$clog2(FIFO_DEPTH):0]       fill,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  drop_cnt
);
    localparam int LANE_W = CHANNELS * SAMPLE_W;
    localparam int WORD_W = PACK * LANE_W;
    localparam int CW     = $clog2(PACK);
    localparam logic [CW-1:0] LAST_SLOT = CW'(PACK - 1);

    logic [CW-1:0]              cnt;
    logic [CW-1:0]              idx;
    logic [SAMPLE_W-1:0]        ramp;
    logic                       mode_q;
    logic [(PACK-1)*LANE_W-1:0] slots;
    logic [LANE_W-1:0]          sample;
    logic [WORD_W-1:0]          word;
    logic                       accept;
    logic                       mode_change;
    logic                       last;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic                       drop;

    assign accept      = en && in_valid;
    assign mode_change = (mode != mode_q);
    // A mode change restarts the word, so the sample on that edge lands in slot 0.
    assign idx         = mode_change ? '0 : cnt;
    assign last        = accept && (idx == LAST_SLOT);
    assign pop         = out_valid && out_ready;
    assign drop        = last && full && !pop;
    assign out_valid   = !empty;
    assign sample      = (mode == MODE_RAMP) ? {CHANNELS{ramp}} : in_data;
    assign word        = {sample, slots};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ramp     <= '0;
            mode_q   <= MODE_ADC;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            mode_q <= mode;
            if (!en) begin
                cnt <= '0;
            end else if (accept) begin
                ramp <= ramp + 1'b1;
                cnt  <= last ? '0 : idx + 1'b1;
            end else if (mode_change) begin
                cnt <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PACK - 1; k++) begin
            if (accept && !last && idx == CW'(k)) slots[k*LANE_W +: LANE_W] <= sample;
        end
    end

    adc_pack_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (last),
        .push_data (word),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .fill      (fill)
    );
endmodule
